// File: rtl/hilo_multiplier.sv
// hilo_multiplier: unsigned WIDTH x WIDTH multiplier with a single registered
// stage. The 2*WIDTH-bit product is returned as two WIDTH-bit halves.
//
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-low reset; clears the product register
//   io_A   - multiplicand, unsigned
//   io_B   - multiplier, unsigned
//   io_Hi  - product bits [2*WIDTH-1:WIDTH], registered
//   io_Lo  - product bits [WIDTH-1:0], registered
module hilo_multiplier #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_A,
  input  logic [WIDTH-1:0] io_B,
  output logic [WIDTH-1:0] io_Hi,
  output logic [WIDTH-1:0] io_Lo
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0] prod_c;
  logic [PW-1:0] prod_q;

  // Partial products folded into a sum/carry pair one row at a time with
  // 3:2 compressors, then resolved by a single carry-propagate add. Carries
  // shifted out of the top bit are always zero because A*B < 2^PW.
  function automatic logic [PW-1:0] csa_product(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [PW-1:0] row;
    logic [PW-1:0] sum_v;
    logic [PW-1:0] carry_v;
    logic [PW-1:0] sum_n;
    sum_v   = PW'(a & {WIDTH{b[0]}});
    carry_v = '0;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      row     = PW'(a & {WIDTH{b[i]}}) << i;
      sum_n   = sum_v ^ carry_v ^ row;
      carry_v = ((sum_v & carry_v) | (sum_v & row) | (carry_v & row)) << 1;
      sum_v   = sum_n;
    end
    return sum_v + carry_v;
  endfunction

  // Combinational multiplier array between the ports and the register.
  always_comb begin
    prod_c = csa_product(io_A, io_B);
  end

  // Product register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prod_q <= '0;
    end else begin
      prod_q <= prod_c;
    end
  end

  assign io_Hi = prod_q[PW-1:WIDTH];
  assign io_Lo = prod_q[WIDTH-1:0];

endmodule

// File: tb/tb_hilo_multiplier.sv
// Self-checking bench for hilo_multiplier (WIDTH=16): directed test-plan
// vectors, asynchronous reset behaviour and a randomized regression against
// a plain arithmetic reference product.
module tb_hilo_multiplier;

  localparam int unsigned W = 16;

  logic         clock;
  logic         reset;
  logic [W-1:0] io_A;
  logic [W-1:0] io_B;
  logic [W-1:0] io_Hi;
  logic [W-1:0] io_Lo;

  int unsigned  n_vec;
  int unsigned  n_err;
  logic [31:0]  exp_prev;

  hilo_multiplier #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .io_A  (io_A),
    .io_B  (io_B),
    .io_Hi (io_Hi),
    .io_Lo (io_Lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts and reports every check.
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {hi,lo}=%h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    return 32'(a) * 32'(b);
  endfunction

  // Drive a pair at the falling edge, confirm the output still holds the
  // previous product, then confirm the new product one edge later.
  task automatic apply(input string tag, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [31:0] exp);
    @(negedge clock);
    io_A = a;
    io_B = b;
    #1;
    check({tag, "_hold"}, {io_Hi, io_Lo}, exp_prev);
    @(posedge clock);
    #1;
    check(tag, {io_Hi, io_Lo}, exp);
    exp_prev = exp;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    exp_prev = '0;
    reset    = 1'b0;
    io_A     = 16'hFFFF;
    io_B     = 16'hFFFF;

    // Reset held: outputs stay zero across clock edges.
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check("rst_hold", {io_Hi, io_Lo}, 32'h0);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_release", {io_Hi, io_Lo}, 32'h0);
    @(posedge clock);
    #1;
    check("max_operands", {io_Hi, io_Lo}, 32'hFFFE_0001);
    exp_prev = 32'hFFFE_0001;

    // Directed test-plan vectors.
    apply("t1234x5678", 16'h1234, 16'h5678, 32'h0626_0060);
    apply("t8000x0002", 16'h8000, 16'h0002, 32'h0001_0000);
    apply("t00FFx0100", 16'h00FF, 16'h0100, 32'h0000_FF00);
    apply("s0",         16'h0000, 16'h1234, 32'h0000_0000);
    apply("s1",         16'h0001, 16'hFFFF, 32'h0000_FFFF);
    apply("s2",         16'hFFFF, 16'h0001, 32'h0000_FFFF);
    apply("s3",         16'h0002, 16'h8000, 32'h0001_0000);
    apply("b_zero",     16'hABCD, 16'h0000, 32'h0000_0000);
    apply("max_again",  16'hFFFF, 16'hFFFF, 32'hFFFE_0001);

    // Asynchronous reset between edges while outputs are nonzero.
    @(negedge clock);
    io_A = 16'h7777;
    io_B = 16'h3333;
    #2;
    reset = 1'b0;
    #1;
    check("async_rst", {io_Hi, io_Lo}, 32'h0);
    @(posedge clock);
    #1;
    check("async_rst_edge", {io_Hi, io_Lo}, 32'h0);
    @(negedge clock);
    io_A  = 16'h0101;
    io_B  = 16'h0303;
    reset = 1'b1;
    #1;
    check("async_release", {io_Hi, io_Lo}, 32'h0);
    @(posedge clock);
    #1;
    check("first_after_rst", {io_Hi, io_Lo}, 32'h0003_0603);
    exp_prev = 32'h0003_0603;

    // Randomized regression.
    for (int i = 0; i < 10000; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom);
      b = W'($urandom);
      apply("random", a, b, ref_mul(a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
